// File: rtl/multi_toggle_gen_pkg.sv
// Shared types and defaults for the multi-channel toggle generator.
package multi_toggle_gen_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    localparam int unsigned DefNumCh = 2;
    localparam int unsigned DefCntW  = 8;
    localparam int unsigned DefHalf  = 5;

    // Channel index width, at least one bit even for a single channel.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_channel.sv
// One toggle channel: half-period config register, counter, output and tick.
module toggle_channel
    import multi_toggle_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned DEFAULT_HALF = DefHalf
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             en,
    input  logic             sync_start,
    output logic             tog_out,
    output logic             tick
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    always_comb begin
        cfg_d    = cfg_we ? cfg_half : cfg_q;
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        tick_d   = 1'b0;

        if (!en) begin
            state_d = StIdle;
            out_d   = 1'b0;
            cnt_d   = '0;
        end else if (sync_start || (state_q == StIdle)) begin
            state_d  = StRun;
            cnt_d    = '0;
            out_d    = 1'b0;
            active_d = cfg_q;
        end else if (active_q == '0) begin
            // Zero half-period holds the level and keeps polling the config.
            active_d = cfg_q;
        end else if (cnt_q == active_q - CNT_W'(1)) begin
            cnt_d    = '0;
            out_d    = ~out_q;
            tick_d   = 1'b1;
            active_d = cfg_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cfg_q    <= CNT_W'(DEFAULT_HALF);
            active_q <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign tog_out = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/multi_toggle_gen.sv
// Multi-channel programmable toggle generator: config decode and sync fan-out.
module multi_toggle_gen
    import multi_toggle_gen_pkg::*;
#(
    parameter int unsigned NUM_CH       = DefNumCh,
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned DEFAULT_HALF = DefHalf
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [idx_width(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]             cfg_half,
    input  logic [NUM_CH-1:0]            en,
    input  logic                         sync_start,
    output logic [NUM_CH-1:0]            tog_out,
    output logic [NUM_CH-1:0]            tick
);

    localparam int unsigned ChW = idx_width(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;

        // Indices past NUM_CH never match, so such writes are dropped.
        assign ch_we = cfg_we && (cfg_ch == ChW'(i));

        toggle_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .cfg_we     (ch_we),
            .cfg_half   (cfg_half),
            .en         (en[i]),
            .sync_start (sync_start),
            .tog_out    (tog_out[i]),
            .tick       (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_toggle_gen.sv
// Self-checking bench for multi_toggle_gen against an absolute-time reference model.
module tb_multi_toggle_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_ch = 1'b0;
    logic [7:0] cfg_half = 8'd0;
    logic [1:0] en = 2'b00;
    logic       sync_start = 1'b0;
    logic [1:0] tog_out;
    logic [1:0] tick;

    int checks = 0;
    int errors = 0;

    multi_toggle_gen #(
        .NUM_CH       (2),
        .CNT_W        (8),
        .DEFAULT_HALF (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .en         (en),
        .sync_start (sync_start),
        .tog_out    (tog_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Reference model: each running channel knows the absolute edge of its next toggle.
    logic [1:0] m_lvl;
    logic [1:0] m_tk;
    logic       m_run [2];
    int         m_nxt [2];
    int         m_cfg [2];
    int         cyc = 0;

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0;
            m_nxt[i] = -1;
            m_cfg[i] = 5;
        end
        m_lvl = 2'b00;
        m_tk  = 2'b00;
    endtask

    task automatic m_step(input logic [1:0] e, input logic s, input logic we, input logic ch,
                          input logic [7:0] h);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int c;
            c = m_cfg[i];
            if (!e[i]) begin
                m_run[i] = 1'b0;
                m_lvl[i] = 1'b0;
                m_tk[i]  = 1'b0;
            end else if (s || !m_run[i]) begin
                m_run[i] = 1'b1;
                m_lvl[i] = 1'b0;
                m_tk[i]  = 1'b0;
                m_nxt[i] = (c == 0) ? -1 : cyc + c;
            end else if (m_nxt[i] < 0) begin
                m_tk[i] = 1'b0;
                if (c != 0) m_nxt[i] = cyc + c;
            end else if (cyc == m_nxt[i]) begin
                m_lvl[i] = ~m_lvl[i];
                m_tk[i]  = 1'b1;
                m_nxt[i] = (c == 0) ? -1 : cyc + c;
            end else begin
                m_tk[i] = 1'b0;
            end
        end
        if (we) m_cfg[ch] = int'(h);
    endtask

    // Drive one cycle of inputs, advance DUT and model, return 1 time unit after the edge.
    task automatic cycle(input logic [1:0] e, input logic s, input logic we, input logic ch,
                         input logic [7:0] h);
        en = e; sync_start = s; cfg_we = we; cfg_ch = ch; cfg_half = h;
        @(posedge clk);
        m_step(e, s, we, ch, h);
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        #12;
        checks++;
        if (tog_out !== 2'b00 || tick !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: tog_out=%b tick=%b expected 00/00", tog_out, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL reset_idle: tog_out=%b tick=%b expected %b/%b",
                         tog_out, tick, m_lvl, m_tk);
            end
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k <= 22; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL basic k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
            if (k == 5 || k == 10) begin
                checks++;
                if (tog_out !== ((k == 5) ? 2'b11 : 2'b00) || tick !== 2'b11) begin
                    errors++;
                    $display("FAIL basic_edge%0d: tog_out=%b tick=%b", k, tog_out, tick);
                end
            end
        end
    endtask

    task automatic test_two_rates();
        cycle(2'b00, 1'b0, 1'b1, 1'b1, 8'd10);
        cycle(2'b00, 1'b0, 1'b1, 1'b0, 8'd5);
        for (int k = 0; k < 45; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL two_rates k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
    endtask

    task automatic test_reconfig();
        bit found = 0;
        cycle(2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
        for (int k = 0; k < 20; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL reconfig k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_nxt[0] == cyc + 1) found = 1;
            else cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reconfig_boundary: boundary not reached within 20 cycles");
        end
        cycle(2'b11, 1'b0, 1'b1, 1'b0, 8'd4);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL reconfig_on_boundary k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        end
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < 20 && m_lvl[0] !== 1'b1; k++) cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (tog_out[0] !== 1'b0 || tick[0] !== 1'b0 || tog_out !== m_lvl || tick !== m_tk) begin
            errors++;
            $display("FAIL enable_drop: tog_out=%b tick=%b expected %b/%b",
                     tog_out, tick, m_lvl, m_tk);
        end
        cycle(2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 15; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL reenable k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
    endtask

    task automatic test_sync();
        cycle(2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
        cycle(2'b11, 1'b0, 1'b1, 1'b1, 8'd7);
        for (int k = 0; k < 17; k++) cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0, 8'd6);
        checks++;
        if (tog_out !== 2'b00 || tick !== 2'b00 || tog_out !== m_lvl || tick !== m_tk) begin
            errors++;
            $display("FAIL sync_align: tog_out=%b tick=%b expected 00/00", tog_out, tick);
        end
        cycle(2'b11, 1'b0, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 40; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL sync_run k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
        checks++;
        if (tick[1] !== 1'b0) begin
            errors++;
            $display("FAIL half_zero_hold: tick[1]=%b expected 0", tick[1]);
        end
    endtask

    task automatic test_async_reset();
        cycle(2'b11, 1'b0, 1'b1, 1'b1, 8'd1);
        for (int k = 0; k < 6; k++) cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tog_out !== 2'b00 || tick !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: tog_out=%b tick=%b expected 00/00", tog_out, tick);
        end
        en = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        cycle(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k <= 12; k++) begin
            cycle(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL post_reset k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] e = 2'b11;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) e = 2'($urandom);
            cycle(e, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 8'($urandom_range(0, 6)));
            checks++;
            if (tog_out !== m_lvl || tick !== m_tk) begin
                errors++;
                $display("FAIL random k=%0d: tog_out=%b tick=%b expected %b/%b",
                         k, tog_out, tick, m_lvl, m_tk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_rates();
        test_reconfig();
        test_enable_drop();
        test_sync();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_toggle_gen.md
# multi_toggle_gen

Multi-channel programmable square-wave and toggle generator. It is the synthesizable, parametrised successor to the fixed-period free-running toggle stimulus used in benches. Each of NUM_CH channels toggles its output every programmed number of clock cycles, and all enabled channels can be phase-aligned with a single sync pulse. The block sits between a simple config port and any logic that needs periodic strobes or divided clocks-as-data.

## Interface
- NUM_CH, 2: number of independent channels.
- CNT_W, 8: width of half-period value and per-channel counter.
- DEFAULT_HALF, 5: half-period loaded into every channel's config register at reset.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  write strobe for half-period config.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for write.
- cfg_half  in  CNT_W  half-period in cycles; 0 = hold.
- en  in  NUM_CH  per-channel run enable, level.
- sync_start  in  1  one-cycle pulse restarting all enabled channels in phase.
- tog_out  out  NUM_CH  per-channel toggle output.
- tick  out  NUM_CH  one-cycle pulse, high in the cycle tog_out[i] changes.

## Operation
- Per channel state: IDLE, RUN. Per channel registers: cfg (CNT_W), active half (CNT_W), cnt (CNT_W), out, tick.
- Reset: state IDLE; cnt 0; active 0; tog_out 0; tick 0; every cfg = DEFAULT_HALF.
- Config: on cfg_we, cfg[cfg_ch] <= cfg_half. An out-of-range cfg_ch is ignored. The write is visible in cfg the next cycle.
- IDLE -> RUN when en[i]=1 is sampled. On that edge: cnt <= 0, active <= cfg, out stays 0.
- RUN, active != 0: cnt increments each cycle. When cnt == active-1: cnt <= 0, out <= ~out, tick <= 1, active <= cfg (pre-edge value). Otherwise tick <= 0.
- RUN, active == 0: out and cnt hold, tick 0, and active <= cfg every cycle.
- RUN -> IDLE when en[i]=0 is sampled. On that edge: out <= 0, cnt <= 0, tick <= 0. No tick is generated for the forced low.
- sync_start sampled high: every channel with en[i]=1 (IDLE or RUN) goes to RUN with cnt <= 0, out <= 0, active <= cfg, tick <= 0. No tick fires for the forced low.
- Priority per channel: rst_n > en=0 > sync_start > boundary toggle > count.
- Arithmetic: cnt is unsigned CNT_W. cnt compares against active-1 and never wraps past active-1. Max half = 2^CNT_W - 1.

## Timing
- Enable sampled at edge E: first toggle at edge E+H, then every H edges. Period is 2H cycles with 50% duty.
- tick is registered and coincident with the tog_out change, so it has zero extra latency relative to tog_out.
- Reconfiguration takes effect at the next toggle boundary after the written value is visible. A write in the same cycle as a boundary takes effect one boundary later.
- H=1: out toggles every cycle and tick is held high continuously.
- sync_start in the same cycle as a boundary: sync wins, out <= 0, no tick.
- Async reset mid-run: outputs go to 0 immediately on rst_n low, independent of clk. After rst_n rises, cfg is back at DEFAULT_HALF.

## Structure
- Package multi_toggle_gen_pkg holds the channel state enum (IDLE, RUN) and the default-width constants.
- Sub-module toggle_channel implements one channel's state, counter and output. It is instantiated NUM_CH times via generate. The top level holds config decode and fans out sync_start.

## Test plan
- Reset release, cfg defaults (5), en=2'b11 at edge 0 -> both outputs rise at edge 5 and fall at edge 10. tick[1:0]=2'b11 at edges 5, 10, ...
- Write ch1 half=10 before enabling, then en=2'b11 -> ch0 toggles every 5 cycles and ch1 every 10. The edges line up, like a=~a every 5 and b=~b every 10.
- Write ch0 half=3 while ch0 runs at 5 -> the current 5-cycle segment completes, then toggles occur every 3 cycles. A write landing exactly on a boundary delays the change by one segment.
- Drop en[0] mid-high -> tog_out[0]=0 next edge, no tick. Re-assert en[0] -> first toggle H cycles later.
- Channels run out of phase, then pulse sync_start -> both outputs go to 0 on the same edge and toggle together H cycles later. Half=0 on a channel -> it holds its level with no ticks.
- Assert rst_n low mid-run between edges -> tog_out and tick go to 0 immediately. After release, cfg=5 and channels are IDLE until en is sampled.
